hx8352_bus_writer: RTL and testbench

//  Drives the HX8352 8080-style parallel write bus (RS, WR_n, RD_n, DB) on

---
 rtl/hx8352_bus_writer.sv | 142 ++++++++++++++
 tb/tb_hx8352_bus_writer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/hx8352_bus_writer.sv
// hx8352_bus_writer: turns one bus_step request into one timed 8080-style
// write strobe (RS, WR_n, DB) on the HX8352 panel bus and pulses bus_done.
// Build option: define HX8352_BUS_WRITER_8BIT_EN for 8-bit bus mode, where
// each word is sent as two strobes, high byte first, on lcd_data[7:0].
module hx8352_bus_writer #(
    parameter int SETUP_CYCLES   = 1,
    parameter int WR_LOW_CYCLES  = 2,
    parameter int WR_HIGH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_step,
    input  logic        command_or_data,
    input  logic [15:0] data_to_write,
    output logic        bus_done,
    output logic        busy,
    output logic        lcd_rs,
    output logic        lcd_wr_n,
    output logic        lcd_rd_n,
    output logic [15:0] lcd_data
);

`ifdef HX8352_BUS_WRITER_8BIT_EN
    localparam bit BYTE_MODE = 1'b1;
`else
    localparam bit BYTE_MODE = 1'b0;
`endif

    // Phase counters are loaded with N-1 and count down to zero.
    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] LOW_LD   = 8'(WR_LOW_CYCLES - 1);
    localparam logic [7:0] HIGH_LD  = 8'(WR_HIGH_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WR_LOW,
        WR_HIGH,
        DONE
    } state_t;

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic        second, second_n;   // second byte strobe in 8-bit mode
    logic [7:0]  lo_byte, lo_byte_n; // low byte held for the second strobe
    logic        rs_n;
    logic [15:0] data_n;
    logic        wr_n_n, done_n, busy_n;

    // Next-state, phase counter and next registered output values.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        second_n  = second;
        lo_byte_n = lo_byte;
        rs_n      = lcd_rs;
        data_n    = lcd_data;
        case (state)
            IDLE: begin
                if (bus_step) begin
                    rs_n      = command_or_data;
                    lo_byte_n = data_to_write[7:0];
                    data_n    = BYTE_MODE ? {8'h00, data_to_write[15:8]} : data_to_write;
                    second_n  = 1'b0;
                    cnt_n     = SETUP_LD;
                    state_n   = SETUP;
                end
            end
            SETUP: begin
                if (cnt == 8'd0) begin
                    cnt_n   = LOW_LD;
                    state_n = WR_LOW;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            WR_LOW: begin
                if (cnt == 8'd0) begin
                    cnt_n   = HIGH_LD;
                    state_n = WR_HIGH;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            WR_HIGH: begin
                if (cnt == 8'd0) begin
                    if (BYTE_MODE && !second) begin
                        // Re-run the strobe sequence for the low byte.
                        second_n = 1'b1;
                        data_n   = {8'h00, lo_byte};
                        cnt_n    = SETUP_LD;
                        state_n  = SETUP;
                    end else begin
                        cnt_n   = 8'd0;
                        state_n = DONE;
                    end
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                cnt_n   = 8'd0;
                state_n = IDLE;
            end
        endcase
        // Outputs are registered from the next state so they line up with it.
        wr_n_n = (state_n != WR_LOW);
        done_n = (state_n == DONE);
        busy_n = (state_n != IDLE);
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            second   <= 1'b0;
            lo_byte  <= 8'd0;
            lcd_rs   <= 1'b0;
            lcd_data <= 16'd0;
            lcd_wr_n <= 1'b1;
            lcd_rd_n <= 1'b1;
            bus_done <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            second   <= second_n;
            lo_byte  <= lo_byte_n;
            lcd_rs   <= rs_n;
            lcd_data <= data_n;
            lcd_wr_n <= wr_n_n;
            lcd_rd_n <= 1'b1;
            bus_done <= done_n;
            busy     <= busy_n;
        end
    end

endmodule

// File: tb/tb_hx8352_bus_writer.sv
// Bench for hx8352_bus_writer: table-driven transfers with per-record
// expectations, hand sequences for reset corners, then random traffic,
// all checked cycle by cycle against a timeline model of the bus.
module tb_hx8352_bus_writer;
    localparam int S = 1;
    localparam int L = 2;
    localparam int H = 2;
`ifdef HX8352_BUS_WRITER_8BIT_EN
    localparam int ROUNDS = 2;
`else
    localparam int ROUNDS = 1;
`endif
    localparam int R   = S + L + H;
    localparam int LAT = ROUNDS * R + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bus_step = 1'b0;
    logic        command_or_data = 1'b0;
    logic [15:0] data_to_write = 16'h0;
    logic        bus_done, busy, lcd_rs, lcd_wr_n, lcd_rd_n;
    logic [15:0] lcd_data;

    hx8352_bus_writer #(.SETUP_CYCLES(S), .WR_LOW_CYCLES(L), .WR_HIGH_CYCLES(H)) dut (
        .clk(clk), .rst(rst), .bus_step(bus_step), .command_or_data(command_or_data),
        .data_to_write(data_to_write), .bus_done(bus_done), .busy(busy),
        .lcd_rs(lcd_rs), .lcd_wr_n(lcd_wr_n), .lcd_rd_n(lcd_rd_n), .lcd_data(lcd_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Timeline model: k counts cycles since the accepting edge (1..LAT).
    logic        m_active = 1'b0;
    int          m_k = 0;
    logic        m_rs = 1'b0;
    logic [15:0] m_word = 16'h0;
    logic [15:0] m_data = 16'h0;
    logic        prev_wr_n = 1'b1;
    logic        rose;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] strobe_word(input logic [15:0] w, input int rnd);
        if (ROUNDS == 2) return (rnd == 0) ? {8'h00, w[15:8]} : {8'h00, w[7:0]};
        return w;
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_active = 1'b0; m_k = 0; m_rs = 1'b0; m_data = 16'h0;
        end else if (m_active) begin
            if (m_k == LAT) m_active = 1'b0;
            else m_k++;
        end else if (bus_step) begin
            m_active = 1'b1; m_k = 1; m_rs = command_or_data; m_word = data_to_write;
        end
    endtask

    task automatic check_all();
        logic e_wr_n, e_done, e_busy;
        int idx, rnd;
        e_wr_n = 1'b1; e_done = 1'b0; e_busy = 1'b0;
        if (m_active) begin
            idx = (m_k - 1) % R;
            rnd = (m_k - 1) / R;
            e_busy = 1'b1;
            e_done = (m_k == LAT);
            e_wr_n = !(m_k < LAT && idx >= S && idx < S + L);
            m_data = strobe_word(m_word, (rnd >= ROUNDS) ? ROUNDS - 1 : rnd);
        end
        chk("wr_n", 16'(lcd_wr_n), 16'(e_wr_n));
        chk("rd_n", 16'(lcd_rd_n), 16'h1);
        chk("bus_done", 16'(bus_done), 16'(e_done));
        chk("busy", 16'(busy), 16'(e_busy));
        chk("rs", 16'(lcd_rs), 16'(m_rs));
        chk("data", lcd_data, m_data);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        rose = (prev_wr_n === 1'b0) && (lcd_wr_n === 1'b1) && !rst;
        prev_wr_n = lcd_wr_n;
    endtask

    typedef struct {
        logic        cod;
        logic [15:0] data;
        int          step2_at;  // tick of an extra step (-1 = none)
        int          rst_at;    // tick of a reset pulse (-1 = none)
        int          exp_dones; // bus_done pulses expected in the window
        int          exp_rises; // completed wr_n strobes expected
    } rec_t;

    rec_t tbl[6];

    initial begin
        int dones, rises;
        tbl[0] = '{1'b0, 16'h0022, -1, -1, 1, ROUNDS};
        tbl[1] = '{1'b1, 16'hAABB, -1, -1, 1, ROUNDS};
        tbl[2] = '{1'b1, 16'h1234, -1, -1, 1, ROUNDS};
        tbl[3] = '{1'b1, 16'h5A5A,  3, -1, 1, ROUNDS};
        tbl[4] = '{1'b0, 16'hBEEF, -1,  2, 0, 0};
        tbl[5] = '{1'b1, 16'hFFFF, LAT, -1, 1, ROUNDS};

        // Reset held for three cycles.
        rst = 1'b1;
        repeat (3) tick();
        chk("reset_wr_n", 16'(lcd_wr_n), 16'h1);
        chk("reset_rd_n", 16'(lcd_rd_n), 16'h1);
        chk("reset_rs", 16'(lcd_rs), 16'h0);
        chk("reset_data", lcd_data, 16'h0);
        chk("reset_done", 16'(bus_done), 16'h0);
        chk("reset_busy", 16'(busy), 16'h0);
        rst = 1'b0;
        tick();

        // Table-driven transfers.
        foreach (tbl[i]) begin
            dones = 0; rises = 0;
            command_or_data = tbl[i].cod;
            data_to_write   = tbl[i].data;
            for (int j = 0; j <= LAT + 2; j++) begin
                bus_step = (j == 0) || (j == tbl[i].step2_at);
                rst      = (j == tbl[i].rst_at);
                tick();
                bus_step = 1'b0;
                rst      = 1'b0;
                if (bus_done === 1'b1) dones++;
                if (rose) begin
                    chk($sformatf("rec%0d_db_at_rise%0d", i, rises), lcd_data,
                        strobe_word(tbl[i].data, rises));
                    rises++;
                end
                if (j == 0) chk($sformatf("rec%0d_rs_cyc1", i), 16'(lcd_rs), 16'(tbl[i].cod));
            end
            chk($sformatf("rec%0d_dones", i), 16'(dones), 16'(tbl[i].exp_dones));
            chk($sformatf("rec%0d_strobes", i), 16'(rises), 16'(tbl[i].exp_rises));
            chk($sformatf("rec%0d_idle_busy", i), 16'(busy), 16'h0);
        end

        // Reset and step in the same cycle: reset wins, nothing starts.
        data_to_write = 16'h7777; command_or_data = 1'b1;
        rst = 1'b1; bus_step = 1'b1;
        tick();
        rst = 1'b0; bus_step = 1'b0;
        tick();
        chk("rst_step_busy", 16'(busy), 16'h0);
        chk("rst_step_wr_n", 16'(lcd_wr_n), 16'h1);
        chk("rst_step_data", lcd_data, 16'h0);

        // Random traffic, including steps while busy and occasional resets.
        for (int n = 0; n < 400; n++) begin
            bus_step        = ($urandom_range(0, 99) < 35);
            rst             = ($urandom_range(0, 99) < 2);
            command_or_data = 1'($urandom_range(0, 1));
            data_to_write   = 16'($urandom);
            tick();
        end
        bus_step = 1'b0; rst = 1'b0;
        repeat (LAT + 2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
